// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way set-associative data cache:
// the controller state encoding and the address-split width helpers.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WRITEBACK   = 2'd1,
      REFILL      = 2'd2,
      REFILL_DONE = 2'd3
   } cacheState_e;

   function automatic int offsetWidth(input int lineBytes);
      return $clog2(lineBytes);
   endfunction

   function automatic int indexWidth(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tagWidth(input int addrW, input int lineBytes, input int sets);
      return addrW - offsetWidth(lineBytes) - indexWidth(sets);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the data cache: per-set valid/dirty/tag/line storage with a
// combinational read port and a single clocked write port.
module dcache_way #(
   parameter int SETS    = 16,
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 23,
   parameter int LINE_W  = 256
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rdIndex_i,
   output logic               rdValid_o,
   output logic               rdDirty_o,
   output logic [TAG_W-1:0]   rdTag_o,
   output logic [LINE_W-1:0]  rdLine_o,
   input  logic               wrEn_i,
   input  logic [INDEX_W-1:0] wrIndex_i,
   input  logic               wrValid_i,
   input  logic               wrDirty_i,
   input  logic [TAG_W-1:0]   wrTag_i,
   input  logic [LINE_W-1:0]  wrLine_i
);

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] line_q [SETS];

   // Only the status bits are cleared; tag and line contents survive reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wrEn_i) begin
         valid_q[wrIndex_i] <= wrValid_i;
         dirty_q[wrIndex_i] <= wrDirty_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         tag_q[wrIndex_i]  <= wrTag_i;
         line_q[wrIndex_i] <= wrLine_i;
      end
   end

   assign rdValid_o = valid_q[rdIndex_i];
   assign rdDirty_o = dirty_q[rdIndex_i];
   assign rdTag_o   = tag_q[rdIndex_i];
   assign rdLine_o  = line_q[rdIndex_i];

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate L1 data cache with 1-bit
// LRU replacement and saturating hit/miss counters.
module dcache_2way_top
   import dcache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 32,
   parameter int SETS       = 16,
   parameter int CNT_W      = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8*LINE_BYTES-1:0] mem_data_i,
   input  logic                    mem_ack_i,
   output logic [8*LINE_BYTES-1:0] mem_data_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    mem_enable_o,
   output logic                    mem_write_o,
   input  logic [31:0]             p1_data_i,
   input  logic [ADDR_W-1:0]       p1_addr_i,
   input  logic                    p1_MemRead_i,
   input  logic                    p1_MemWrite_i,
   output logic [31:0]             p1_data_o,
   output logic                    p1_stall_o,
   output logic [CNT_W-1:0]        hit_cnt_o,
   output logic [CNT_W-1:0]        miss_cnt_o
);

   localparam int LINE_W  = 8 * LINE_BYTES;
   localparam int OW      = offsetWidth(LINE_BYTES);
   localparam int INDEX_W = indexWidth(SETS);
   localparam int TAG_W   = tagWidth(ADDR_W, LINE_BYTES, SETS);
   localparam int WORD_W  = OW - 2;

   cacheState_e       state_q, state_d;
   logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
   logic              victim_q, victim_d;
   logic              memEnable_q, memEnable_d;
   logic              memWrite_q, memWrite_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [LINE_W-1:0] memData_q, memData_d;
   logic [SETS-1:0]   lru_q, lru_d;
   logic              skipHit_q, skipHit_d;
   logic [CNT_W-1:0]  hitCnt_q, hitCnt_d;
   logic [CNT_W-1:0]  missCnt_q, missCnt_d;

   logic [INDEX_W-1:0] index, reqIndex, wrIndex;
   logic [TAG_W-1:0]   tag, reqTag, wrTag, victimTag;
   logic [WORD_W-1:0]  wordSel;
   logic               req, hit, hitWay, victimWay, refillWrite, storeHit, wrDirty;
   logic [1:0]         wayValid, wayDirty, wayHit, wayWrEn;
   logic [TAG_W-1:0]   wayTag  [2];
   logic [LINE_W-1:0]  wayLine [2];
   logic [LINE_W-1:0]  hitLine, victimLine, mergedLine, wrLine;
   logic               unusedAddrBits;

   assign index    = p1_addr_i[OW +: INDEX_W];
   assign tag      = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign wordSel  = p1_addr_i[OW-1:2];
   assign reqIndex = reqAddr_q[OW +: INDEX_W];
   assign reqTag   = reqAddr_q[ADDR_W-1 -: TAG_W];
   assign unusedAddrBits = ^{p1_addr_i[1:0], reqAddr_q[OW-1:0]};

   dcache_way #(.SETS(SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) way0 (
      .clk_i(clk_i), .rst_i(rst_i), .rdIndex_i(index),
      .rdValid_o(wayValid[0]), .rdDirty_o(wayDirty[0]), .rdTag_o(wayTag[0]), .rdLine_o(wayLine[0]),
      .wrEn_i(wayWrEn[0]), .wrIndex_i(wrIndex), .wrValid_i(1'b1), .wrDirty_i(wrDirty),
      .wrTag_i(wrTag), .wrLine_i(wrLine)
   );

   dcache_way #(.SETS(SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) way1 (
      .clk_i(clk_i), .rst_i(rst_i), .rdIndex_i(index),
      .rdValid_o(wayValid[1]), .rdDirty_o(wayDirty[1]), .rdTag_o(wayTag[1]), .rdLine_o(wayLine[1]),
      .wrEn_i(wayWrEn[1]), .wrIndex_i(wrIndex), .wrValid_i(1'b1), .wrDirty_i(wrDirty),
      .wrTag_i(wrTag), .wrLine_i(wrLine)
   );

   assign req        = p1_MemRead_i | p1_MemWrite_i;
   assign wayHit[0]  = wayValid[0] & (wayTag[0] == tag);
   assign wayHit[1]  = wayValid[1] & (wayTag[1] == tag);
   assign hit        = req & (|wayHit);
   assign hitWay     = wayHit[1];
   assign hitLine    = hitWay ? wayLine[1] : wayLine[0];
   assign p1_stall_o = req & ~hit;
   assign p1_data_o  = hit ? hitLine[{wordSel, 5'b0} +: 32] : 32'h0;

   // Fill an empty way first (way0 before way1), otherwise replace the LRU way.
   assign victimWay  = ~wayValid[0] ? 1'b0 : (~wayValid[1] ? 1'b1 : lru_q[index]);
   assign victimTag  = victimWay ? wayTag[1] : wayTag[0];
   assign victimLine = victimWay ? wayLine[1] : wayLine[0];

   assign refillWrite = (state_q == REFILL) & mem_ack_i;
   assign storeHit    = hit & p1_MemWrite_i;

   always_comb begin
      mergedLine = hitLine;
      mergedLine[{wordSel, 5'b0} +: 32] = p1_data_i;
      wayWrEn = '0;
      wrIndex = index;
      wrTag   = tag;
      wrLine  = mergedLine;
      wrDirty = 1'b1;
      if (refillWrite) begin
         wayWrEn[victim_q] = 1'b1;
         wrIndex = reqIndex;
         wrTag   = reqTag;
         wrLine  = mem_data_i;
         wrDirty = 1'b0;
      end else if (storeHit) begin
         wayWrEn[hitWay] = 1'b1;
      end
   end

   // The first IDLE hit after a refill is the stalled request completing, so it is not counted.
   always_comb begin
      state_d     = state_q;
      reqAddr_d   = reqAddr_q;
      victim_d    = victim_q;
      memEnable_d = memEnable_q;
      memWrite_d  = memWrite_q;
      memAddr_d   = memAddr_q;
      memData_d   = memData_q;
      lru_d       = lru_q;
      skipHit_d   = skipHit_q;
      hitCnt_d    = hitCnt_q;
      missCnt_d   = missCnt_q;
      if (hit) begin
         lru_d[index] = ~hitWay;
      end
      case (state_q)
         IDLE: begin
            if (hit) begin
               if (skipHit_q) begin
                  skipHit_d = 1'b0;
               end else if (hitCnt_q != '1) begin
                  hitCnt_d = hitCnt_q + CNT_W'(1);
               end
            end else if (req) begin
               if (missCnt_q != '1) begin
                  missCnt_d = missCnt_q + CNT_W'(1);
               end
               reqAddr_d   = p1_addr_i;
               victim_d    = victimWay;
               memEnable_d = 1'b1;
               if (wayValid[victimWay] & wayDirty[victimWay]) begin
                  state_d    = WRITEBACK;
                  memWrite_d = 1'b1;
                  memAddr_d  = {victimTag, index, {OW{1'b0}}};
                  memData_d  = victimLine;
               end else begin
                  state_d    = REFILL;
                  memWrite_d = 1'b0;
                  memAddr_d  = {tag, index, {OW{1'b0}}};
               end
            end
         end
         WRITEBACK: begin
            if (mem_ack_i) begin
               state_d    = REFILL;
               memWrite_d = 1'b0;
               memAddr_d  = {reqTag, reqIndex, {OW{1'b0}}};
            end
         end
         REFILL: begin
            if (mem_ack_i) begin
               state_d     = REFILL_DONE;
               memEnable_d = 1'b0;
               memWrite_d  = 1'b0;
            end
         end
         REFILL_DONE: begin
            state_d   = IDLE;
            skipHit_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         reqAddr_q   <= '0;
         victim_q    <= 1'b0;
         memEnable_q <= 1'b0;
         memWrite_q  <= 1'b0;
         memAddr_q   <= '0;
         memData_q   <= '0;
         lru_q       <= '0;
         skipHit_q   <= 1'b0;
         hitCnt_q    <= '0;
         missCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         reqAddr_q   <= reqAddr_d;
         victim_q    <= victim_d;
         memEnable_q <= memEnable_d;
         memWrite_q  <= memWrite_d;
         memAddr_q   <= memAddr_d;
         memData_q   <= memData_d;
         lru_q       <= lru_d;
         skipHit_q   <= skipHit_d;
         hitCnt_q    <= hitCnt_d;
         missCnt_q   <= missCnt_d;
      end
   end

   assign mem_enable_o = memEnable_q;
   assign mem_write_o  = memWrite_q;
   assign mem_addr_o   = memAddr_q;
   assign mem_data_o   = memData_q;
   assign hit_cnt_o    = hitCnt_q;
   assign miss_cnt_o   = missCnt_q;

endmodule

// File: tb/tb_dcache_2way_top.sv
// Testbench for dcache_2way_top: directed scenarios plus random traffic checked
// against a per-set recency-list cache model and a line-addressed memory model.
module tb_dcache_2way_top;

   localparam int ADDR_W     = 32;
   localparam int LINE_BYTES = 32;
   localparam int SETS       = 16;
   localparam int CNT_W      = 4;
   localparam int LINE_W     = 8 * LINE_BYTES;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [31:0]       p1_data_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic              p1_MemRead_i;
   logic              p1_MemWrite_i;
   logic [31:0]       p1_data_o;
   logic              p1_stall_o;
   logic [CNT_W-1:0]  hit_cnt_o;
   logic [CNT_W-1:0]  miss_cnt_o;

   dcache_2way_top #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int testsRun = 0;
   int testsFailed = 0;

   // Model: per set, up to two resident lines ordered most-recent first.
   int          setCount   [SETS];
   logic [31:0] entryKey   [SETS][2];
   logic        entryDirty [SETS][2];
   logic [255:0] entryLine [SETS][2];
   logic [255:0] memModel [bit [31:0]];
   int expHit;
   int expMiss;

   logic         obsHit;
   logic         obsFirstWrite;
   logic [31:0]  obsWbAddr;
   logic [255:0] obsWbData;
   logic [31:0]  obsRefillAddr;
   logic [31:0]  obsData;

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   function automatic int satInc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   function automatic logic [255:0] randLine();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic clearModel();
      for (int s = 0; s < SETS; s++) setCount[s] = 0;
      expHit  = 0;
      expMiss = 0;
   endtask

   task automatic respond(input logic [255:0] line);
      int d;
      d = $urandom_range(0, 2);
      repeat (d) begin
         @(posedge clk_i); #1;
      end
      mem_data_i = line;
      mem_ack_i  = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i  = 1'b0;
      mem_data_i = randLine();
   endtask

   task automatic resetDut();
      rst_i = 1'b0;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
      mem_ack_i = 1'b0;
      #1;
      checkOutput("rstEnable", mem_enable_o, 1'b0);
      checkOutput("rstWrite", mem_write_o, 1'b0);
      checkOutput("rstAddr", mem_addr_o, 32'h0);
      checkOutput("rstData", mem_data_o, 256'h0);
      checkOutput("rstHitCnt", hit_cnt_o, 4'h0);
      checkOutput("rstMissCnt", miss_cnt_o, 4'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      clearModel();
   endtask

   task automatic idleCycle();
      @(negedge clk_i);
      checkOutput("idleStall", p1_stall_o, 1'b0);
      checkOutput("idleEnable", mem_enable_o, 1'b0);
      @(posedge clk_i); #1;
   endtask

   // One CPU access, held until the cache completes it (plus one cycle after a refill).
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data);
      int s, w, pos;
      logic [31:0] key, evKey;
      logic [255:0] evLine, fill;
      bit evictDirty;
      s = int'(addr[8:5]);
      w = int'(addr[4:2]);
      key = {addr[31:5], 5'b0};
      pos = -1;
      for (int k = 0; k < setCount[s]; k++) if (entryKey[s][k] == key) pos = k;
      p1_addr_i = addr;
      p1_data_i = data;
      p1_MemWrite_i = isWrite;
      p1_MemRead_i = isWrite ? ($urandom_range(0, 3) == 0) : 1'b1;
      @(negedge clk_i);
      checkOutput("hitCnt", hit_cnt_o, expHit[CNT_W-1:0]);
      checkOutput("missCnt", miss_cnt_o, expMiss[CNT_W-1:0]);
      obsHit = !p1_stall_o;
      obsData = p1_data_o;
      if (pos >= 0) begin
         checkOutput("hitStall", p1_stall_o, 1'b0);
         if (!isWrite) checkOutput("hitData", p1_data_o, entryLine[s][pos][w*32 +: 32]);
         @(posedge clk_i); #1;
         if (isWrite) begin
            entryLine[s][pos][w*32 +: 32] = data;
            entryDirty[s][pos] = 1'b1;
         end
         if (pos == 1) begin
            evKey = entryKey[s][0]; evLine = entryLine[s][0]; evictDirty = entryDirty[s][0];
            entryKey[s][0] = entryKey[s][1]; entryLine[s][0] = entryLine[s][1]; entryDirty[s][0] = entryDirty[s][1];
            entryKey[s][1] = evKey; entryLine[s][1] = evLine; entryDirty[s][1] = evictDirty;
         end
         expHit = satInc(expHit);
      end else begin
         checkOutput("missStall", p1_stall_o, 1'b1);
         checkOutput("missData", p1_data_o, 32'h0);
         expMiss = satInc(expMiss);
         evictDirty = 1'b0;
         if (setCount[s] == 2) begin
            evictDirty = entryDirty[s][1];
            evKey = entryKey[s][1];
            evLine = entryLine[s][1];
            setCount[s] = 1;
            if (evictDirty) memModel[evKey] = evLine;
         end
         @(posedge clk_i); #1;
         obsFirstWrite = mem_write_o;
         if (evictDirty) begin
            obsWbAddr = mem_addr_o;
            obsWbData = mem_data_o;
            checkOutput("wbEnable", mem_enable_o, 1'b1);
            checkOutput("wbWrite", mem_write_o, 1'b1);
            checkOutput("wbAddr", mem_addr_o, evKey);
            checkOutput("wbData", mem_data_o, evLine);
            respond(randLine());
         end
         checkOutput("rfEnable", mem_enable_o, 1'b1);
         checkOutput("rfWrite", mem_write_o, 1'b0);
         checkOutput("rfAddr", mem_addr_o, key);
         obsRefillAddr = mem_addr_o;
         if (!memModel.exists(key)) memModel[key] = randLine();
         fill = memModel[key];
         respond(fill);
         checkOutput("rfDrop", mem_enable_o, 1'b0);
         if (setCount[s] == 1) begin
            entryKey[s][1] = entryKey[s][0]; entryLine[s][1] = entryLine[s][0]; entryDirty[s][1] = entryDirty[s][0];
         end
         setCount[s] = setCount[s] + 1;
         entryKey[s][0] = key;
         entryLine[s][0] = fill;
         entryDirty[s][0] = 1'b0;
         @(negedge clk_i);
         checkOutput("doneStall", p1_stall_o, 1'b0);
         if (!isWrite) checkOutput("doneData", p1_data_o, fill[w*32 +: 32]);
         obsData = p1_data_o;
         if (isWrite) begin
            entryLine[s][0][w*32 +: 32] = data;
            entryDirty[s][0] = 1'b1;
         end
         @(posedge clk_i); #1;
         @(negedge clk_i);
         checkOutput("heldStall", p1_stall_o, 1'b0);
         if (!isWrite) checkOutput("heldData", p1_data_o, entryLine[s][0][w*32 +: 32]);
         @(posedge clk_i); #1;
      end
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [31:0] a;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      p1_data_i = '0;
      p1_addr_i = '0;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
      resetDut();

      // Cold read, then store and re-read within the cached line.
      applyStimulus(1'b0, 32'h040, 32'h0);
      checkOutput("t1Hit", obsHit, 1'b0);
      checkOutput("t1FirstWrite", obsFirstWrite, 1'b0);
      checkOutput("t1RefillAddr", obsRefillAddr, 32'h040);
      @(negedge clk_i);
      checkOutput("t1MissCnt", miss_cnt_o, 4'd1);
      checkOutput("t1HitCnt", hit_cnt_o, 4'd0);
      @(posedge clk_i); #1;
      applyStimulus(1'b1, 32'h044, 32'hDEADBEEF);
      checkOutput("t2StoreHit", obsHit, 1'b1);
      applyStimulus(1'b0, 32'h044, 32'h0);
      checkOutput("t2Data", obsData, 32'hDEADBEEF);
      @(negedge clk_i);
      checkOutput("t2HitCnt", hit_cnt_o, 4'd2);
      @(posedge clk_i); #1;

      // Dirty LRU victim gets written back before the refill.
      applyStimulus(1'b0, 32'h240, 32'h0);
      applyStimulus(1'b0, 32'h240, 32'h0);
      applyStimulus(1'b0, 32'h440, 32'h0);
      checkOutput("t3FirstWrite", obsFirstWrite, 1'b1);
      checkOutput("t3WbAddr", obsWbAddr, 32'h040);
      checkOutput("t3WbWord1", obsWbData[63:32], 32'hDEADBEEF);
      checkOutput("t3RefillAddr", obsRefillAddr, 32'h440);

      // Clean LRU victim is dropped without a write-back.
      resetDut();
      applyStimulus(1'b0, 32'h040, 32'h0);
      applyStimulus(1'b0, 32'h240, 32'h0);
      applyStimulus(1'b0, 32'h040, 32'h0);
      applyStimulus(1'b0, 32'h440, 32'h0);
      checkOutput("t4FirstWrite", obsFirstWrite, 1'b0);
      checkOutput("t4RefillAddr", obsRefillAddr, 32'h440);
      applyStimulus(1'b0, 32'h040, 32'h0);
      checkOutput("t4KeptHit", obsHit, 1'b1);
      applyStimulus(1'b0, 32'h240, 32'h0);
      checkOutput("t4EvictedMiss", obsHit, 1'b0);

      // Hit counter saturation.
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h040, 32'h0);
      @(negedge clk_i);
      checkOutput("hitSat", hit_cnt_o, 4'hF);
      @(posedge clk_i); #1;

      // Reset while a refill is outstanding.
      resetDut();
      p1_addr_i = 32'h040;
      p1_MemRead_i = 1'b1;
      @(negedge clk_i);
      checkOutput("midStall", p1_stall_o, 1'b1);
      @(posedge clk_i); #1;
      checkOutput("midEnable", mem_enable_o, 1'b1);
      checkOutput("midMissCnt", miss_cnt_o, 4'd1);
      rst_i = 1'b0;
      #1;
      checkOutput("midRstEnable", mem_enable_o, 1'b0);
      checkOutput("midRstMissCnt", miss_cnt_o, 4'd0);
      checkOutput("midRstHitCnt", hit_cnt_o, 4'd0);
      p1_MemRead_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      clearModel();
      applyStimulus(1'b0, 32'h040, 32'h0);
      checkOutput("midAfterMiss", obsHit, 1'b0);

      // Random traffic over a few conflicting tags in a handful of sets.
      resetDut();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            idleCycle();
         end else begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            applyStimulus($urandom_range(0, 2) == 0, a, $urandom);
         end
      end
      @(negedge clk_i);
      checkOutput("finalHitCnt", hit_cnt_o, expHit[CNT_W-1:0]);
      checkOutput("finalMissCnt", miss_cnt_o, expMiss[CNT_W-1:0]);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Parametrised, 2-way set-associative, write-back, write-allocate L1 data cache.
- Sits between the CPU data port and the line-wide data memory, replacing the direct-mapped dcache.
- Keeps the same CPU and memory handshake.
- Adds:
  - 1-bit LRU replacement per set
  - configurable geometry
  - saturating hit/miss performance counters

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 32, bytes per line (power of 2); LINE_W = 8*LINE_BYTES
SETS, 16, sets per way (power of 2); INDEX_W = log2(SETS)
CNT_W, 32, performance counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
mem_data_i  in  LINE_W  refill line from memory
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned memory address
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill read
p1_data_i  in  32  CPU store data
p1_addr_i  in  ADDR_W  CPU byte address, word aligned
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request (wins if both are set)
p1_data_o  out  32  load data
p1_stall_o  out  1  CPU must hold its request
hit_cnt_o  out  CNT_W  hit count
miss_cnt_o  out  CNT_W  miss count

Behaviour:
- Address split: offset = addr[OW-1:0] with OW = log2(LINE_BYTES); index = next INDEX_W bits; tag = remaining TAG_W = ADDR_W-OW-INDEX_W bits. addr[1:0] is ignored.
- Per way and per set, storage holds valid, dirty, tag and line.
  - Reads are combinational.
  - Writes happen on posedge clk_i.
- hit = req & (hit0 | hit1), where hitN = validN & (tagN == tag).
  - The comparison is combinational.
  - p1_stall_o = req & ~hit, combinational.
- Read hit: p1_data_o = the 32-bit word at offset[OW-1:2] of the hitting way, zero latency. On a miss, p1_data_o = 0.
- Write hit: on the clock edge the word is merged into the line, dirty is set, and the tag is unchanged.
- LRU: lru[set] names the least-recently-used way. Every hit cycle sets lru[set] = ~hitway.
- Victim choice, in priority order: way0 if invalid; else way1 if invalid; else lru[set].
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE:
    - On req & ~hit, latch the request address and the victim way.
    - If the victim is valid & dirty: go to WRITEBACK with mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line.
    - Otherwise: go to REFILL with mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {latched tag, index, 0}.
  - WRITEBACK: on mem_ack_i, switch to the refill read (mem_write_o = 0, refill address) and go to REFILL.
  - REFILL: on mem_ack_i:
    - write mem_data_i into the victim way with valid = 1, dirty = 0 and the new tag;
    - drop mem_enable_o;
    - go to REFILL_DONE.
  - REFILL_DONE: one cycle, then IDLE. The held request now hits; a store performs its merge then and sets dirty.
- All mem_* outputs are registered.
  - mem_enable_o stays high until the mem_ack_i cycle.
  - mem_ack_i outside WRITEBACK/REFILL is ignored.
- The CPU holds addr, data and read/write stable while stalled. The block uses the latched address for all memory traffic.
- Counters saturate at all-ones.
  - miss_cnt_o increments on each IDLE miss detection.
  - hit_cnt_o increments on each IDLE hit cycle, except the first hit following REFILL_DONE.
- Reset, including mid-transaction:
  - state = IDLE;
  - all valid, dirty and lru bits = 0;
  - mem_enable_o = mem_write_o = 0;
  - mem_addr_o = 0, mem_data_o = 0;
  - counters = 0.
  - Dirty data is discarded. Line data storage is not reset.
- With no request, the FSM stays in IDLE and the storage is unchanged.

Decomposition:
- Shared package dcache_pkg holds:
  - the state encoding (IDLE = 0, WRITEBACK = 1, REFILL = 2, REFILL_DONE = 3);
  - derived-width functions (offset, index and tag widths).
- Sub-module dcache_way holds one way's valid/dirty/tag/line arrays and is instantiated twice:
  - combinational read by index;
  - write port with line data, tag, valid and dirty;
  - async clear of valid/dirty.

Test Plan:
- Cold read of 0x040 → stall asserted, refill read at mem_addr_o = 0x040 with mem_write_o = 0; after ack plus one cycle, p1_data_o equals word 0 of the returned line; miss_cnt = 1, hit_cnt = 0.
- Write 0xDEADBEEF to 0x044 after the line is cached → no stall, same-cycle completion; the next read of 0x044 returns 0xDEADBEEF; hit_cnt = 2.
- Fill set 2 with 0x040 (dirty) and 0x240 (clean), touch 0x240, then read 0x440 → victim is way holding 0x040; write-back at 0x040 carries 0xDEADBEEF in word 1, followed by a refill read of 0x440.
- Read 0x040 then 0x240, then re-read 0x040, then read 0x440 → 0x240 is evicted (LRU) with no write-back because it is clean; 0x040 still hits.
- Assert rst_i low during REFILL while mem_enable_o is high → mem_enable_o = 0 immediately; counters = 0; a subsequent read of 0x040 misses.
- Drive 2^CNT_W hits with CNT_W = 4 → hit_cnt_o holds at 0xF.
